// File: rtl/delay_meas_pkg.sv
// Shared types and default constants for the loopback delay-measurement stage.
package delay_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  localparam int N_SAMP_DEF  = 16;
  localparam int SAMP_W_DEF  = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 4096;
  localparam int IDX_W       = $clog2(N_SAMP_DEF);

  // Result reported when no sample crossed the threshold before the timeout.
  localparam logic [CNT_W_DEF+IDX_W-1:0] RESULT_TIMEOUT = '1;

endpackage

// File: rtl/delay_meas_hit.sv
// Combinational threshold detector: parallel signed compares, lowest sample index wins.
module delay_meas_hit #(
  parameter int N_SAMP = 16,
  parameter int SAMP_W = 16
) (
  input  logic [N_SAMP*SAMP_W-1:0]   adc_word,
  input  logic [SAMP_W-1:0]          threshold,
  output logic                       any_hit,
  output logic [$clog2(N_SAMP)-1:0]  hit_idx
);

  localparam int IDX_W_L = $clog2(N_SAMP);

  logic [N_SAMP-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SAMP; i++) begin
      hit[i] = $signed(adc_word[i*SAMP_W +: SAMP_W]) > $signed(threshold);
    end
  end

  // Scan from the top down so the earliest-in-time sample overwrites later ones.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SAMP - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        hit_idx = IDX_W_L'(i);
      end
    end
  end

endmodule

// File: rtl/delay_meas.sv
// Loopback delay measurement: counts cycles from a trig rising edge until the ADC
// word first shows a sample above threshold, reporting coarse/fine/total delay.
module delay_meas
  import delay_meas_pkg::*;
#(
  parameter int N_SAMP  = N_SAMP_DEF,
  parameter int SAMP_W  = SAMP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              trig,
  input  logic [N_SAMP*SAMP_W-1:0]          adc_word,
  input  logic [SAMP_W-1:0]                 threshold,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout,
  output logic [CNT_W-1:0]                  coarse_cnt,
  output logic [$clog2(N_SAMP)-1:0]         fine_idx,
  output logic [CNT_W+$clog2(N_SAMP)-1:0]   delay_total
);

  localparam int IDX_W_L = $clog2(N_SAMP);
  localparam int DT_W    = CNT_W + IDX_W_L;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  if ((1 << IDX_W_L) != N_SAMP) begin : g_nsamp_pow2
    $error("delay_meas: N_SAMP must be a power of two");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (64'd1 << CNT_W)) begin : g_timeout_range
    $error("delay_meas: TIMEOUT must lie in [1, 2**CNT_W)");
  end

  state_t state, state_n;
  logic [CNT_W-1:0]   counter, counter_n;
  logic               trig_q;
  logic               edge_det;
  logic               any_hit;
  logic [IDX_W_L-1:0] hit_idx;
  logic               busy_n, done_n, timeout_n;
  logic [CNT_W-1:0]   coarse_n;
  logic [IDX_W_L-1:0] fine_n;
  logic [DT_W-1:0]    total_n;

  delay_meas_hit #(
    .N_SAMP (N_SAMP),
    .SAMP_W (SAMP_W)
  ) u_hit (
    .adc_word  (adc_word),
    .threshold (threshold),
    .any_hit   (any_hit),
    .hit_idx   (hit_idx)
  );

  assign edge_det = trig & ~trig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    counter_n = counter;
    busy_n    = busy;
    done_n    = 1'b0;
    timeout_n = 1'b0;
    coarse_n  = coarse_cnt;
    fine_n    = fine_idx;
    total_n   = delay_total;
    case (state)
      ST_IDLE: begin
        if (edge_det) begin
          state_n   = ST_COUNT;
          counter_n = '0;
          busy_n    = 1'b1;
        end
      end
      ST_COUNT: begin
        // A hit on the final counted cycle still beats the timeout.
        if (any_hit) begin
          coarse_n = counter;
          fine_n   = hit_idx;
          total_n  = {counter, hit_idx};
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = ST_WAIT_LOW;
        end else if (counter == LAST_CNT) begin
          coarse_n  = '1;
          fine_n    = '1;
          total_n   = '1;
          timeout_n = 1'b1;
          busy_n    = 1'b0;
          state_n   = ST_WAIT_LOW;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        if (!trig) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // trig_q resets high so a trig already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q      <= 1'b1;
      counter     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      coarse_cnt  <= '0;
      fine_idx    <= '0;
      delay_total <= '0;
    end else begin
      trig_q      <= trig;
      counter     <= counter_n;
      busy        <= busy_n;
      done        <= done_n;
      timeout     <= timeout_n;
      coarse_cnt  <= coarse_n;
      fine_idx    <= fine_n;
      delay_total <= total_n;
    end
  end

endmodule

// File: tb/tb_delay_meas.sv
// Scoreboard bench for delay_meas: stimulus pushes expected results, a monitor pops them.
module tb_delay_meas;
  import delay_meas_pkg::*;

  localparam int NS = 16;
  localparam int SW = 16;
  localparam int CW = 16;
  localparam int IW = 4;
  localparam int TO = 64;
  localparam int WW = NS * SW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             trig = 1'b1;
  logic [WW-1:0]    adc_word = '0;
  logic [SW-1:0]    threshold = '0;
  logic             busy, done, timeout;
  logic [CW-1:0]    coarse_cnt;
  logic [IW-1:0]    fine_idx;
  logic [CW+IW-1:0] delay_total;

  delay_meas #(
    .N_SAMP  (NS),
    .SAMP_W  (SW),
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .adc_word    (adc_word),
    .threshold   (threshold),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .coarse_cnt  (coarse_cnt),
    .fine_idx    (fine_idx),
    .delay_total (delay_total)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_to;
    int coarse;
    int fine;
    int total;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: first sample (earliest index) strictly above the signed threshold.
  function automatic int ref_hit(input logic [WW-1:0] w, input int thr);
    for (int i = 0; i < NS; i++) begin
      int s;
      s = int'($signed(w[i*SW +: SW]));
      if (s > thr) return i;
    end
    return -1;
  endfunction

  function automatic logic [WW-1:0] fill(input int v);
    logic [WW-1:0] w;
    for (int i = 0; i < NS; i++) w[i*SW +: SW] = SW'(v);
    return w;
  endfunction

  function automatic logic [WW-1:0] rand_word(input int thr);
    logic [WW-1:0] w;
    for (int i = 0; i < NS; i++) begin
      int v;
      v = -32768 + int'($urandom_range(thr + 32768));
      w[i*SW +: SW] = SW'(v);
    end
    if ($urandom_range(7) == 0) begin
      int k;
      k = int'($urandom_range(NS - 1));
      w[k*SW +: SW] = SW'($urandom);
    end
    return w;
  endfunction

  // Monitor: every done/timeout pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("done_timeout_exclusive", longint'(done & timeout), 0);
      if (done || timeout) begin
        if (q.size() == 0) begin
          check("unexpected_done", done, 0);
          check("unexpected_timeout", timeout, 0);
        end else begin
          e = q.pop_front();
          check("event_cycle", cyc, e.at);
          check("timeout_flag", timeout, e.is_to);
          check("done_flag", done, !e.is_to);
          check("coarse_cnt", coarse_cnt, e.coarse);
          check("fine_idx", fine_idx, e.fine);
          check("delay_total", delay_total, e.total);
        end
      end
    end
  end

  // mode 0: word 'pre' until cycle hc, then 'hw'; mode 1: random words.
  task automatic do_meas(input int mode, input int hc, input logic [WW-1:0] pre,
                         input logic [WW-1:0] hw, input int hold, input int glitch_at);
    int rise;
    int idx;
    logic [WW-1:0] w;
    exp_t e;
    @(negedge clk);
    trig = 1'b1;
    rise = cyc;
    for (int j = 0; ; j++) begin
      @(negedge clk);
      if (j == 0) check("busy_on", busy, 1);
      if (mode == 1) w = rand_word(int'($signed(threshold)));
      else           w = (j >= hc) ? hw : pre;
      adc_word = w;
      if (j == glitch_at) trig = 1'b0;
      else if (j == glitch_at + 1) trig = 1'b1;
      idx = ref_hit(w, int'($signed(threshold)));
      if (idx >= 0) begin
        e = '{is_to: 1'b0, coarse: j, fine: idx, total: j * NS + idx, at: cyc + 1};
        q.push_back(e);
        last = e;
        break;
      end
      if (j == TO - 1) begin
        e = '{is_to: 1'b1, coarse: 'hFFFF, fine: 'hF, total: 'hFFFFF, at: cyc + 1};
        q.push_back(e);
        last = e;
        break;
      end
    end
    @(negedge clk);
    check("busy_off", busy, 0);
    adc_word = pre;
    while (cyc - rise < hold) @(negedge clk);
    trig = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_coarse", coarse_cnt, last.coarse);
    check("hold_fine", fine_idx, last.fine);
    check("hold_total", delay_total, last.total);
  endtask

  initial begin
    logic [WW-1:0] w0, w1;

    // Reset with trig held high through release: no measurement may start.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_coarse", coarse_cnt, 0);
    check("rst_fine", fine_idx, 0);
    check("rst_total", delay_total, 0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("no_start_after_rst", busy, 0);
    end
    trig = 1'b0;
    repeat (2) @(negedge clk);

    // Basic hit: sample 3 = 2000 at counter 5.
    threshold = SW'(1000);
    w0 = fill(0);
    w1 = w0; w1[3*SW +: SW] = SW'(2000);
    do_meas(0, 5, w0, w1, 0, -10);

    // Strict compare and lowest-index priority.
    w1 = w0;
    w1[7*SW +: SW]  = SW'(1000);
    w1[9*SW +: SW]  = SW'(1001);
    w1[12*SW +: SW] = SW'(1001);
    do_meas(0, 0, w0, w1, 0, -10);

    // Signed compare; 0x8000 never hits.
    threshold = SW'(-100);
    w0 = fill(-200); w0[4*SW +: SW] = 16'h8000;
    w1 = w0; w1[0 +: SW] = SW'(-50);
    do_meas(0, 2, w0, w1, 0, -10);

    // Timeout, then a hit on the very last counted cycle.
    threshold = SW'(1000);
    w0 = fill(0);
    w1 = w0; w1[15*SW +: SW] = SW'(32767);
    do_meas(0, 1000, w0, w1, 0, -10);
    do_meas(0, TO - 1, w0, w1, 0, -10);

    // Trig held 200 cycles, re-arm, and an edge inside ST_COUNT.
    w1 = w0; w1[6*SW +: SW] = SW'(1500);
    do_meas(0, 10, w0, w1, 200, -10);
    do_meas(0, 4, w0, w1, 0, -10);
    do_meas(0, 10, w0, w1, 30, 3);

    // Reset in the middle of a measurement at counter 20.
    @(negedge clk);
    trig = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      adc_word = w0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_coarse", coarse_cnt, 0);
    check("abort_fine", fine_idx, 0);
    check("abort_total", delay_total, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle_busy", busy, 0);
    do_meas(0, 7, w0, w1, 0, -10);

    // Randomized measurements.
    for (int t = 0; t < 30; t++) begin
      threshold = SW'(int'($urandom_range(4000)) - 2000);
      do_meas(1, 0, fill(-32768), fill(-32768), int'($urandom_range(80)), -10);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
